// File: rtl/im_fetch_port.sv
// im_fetch_port -- synchronous instruction fetch port.
//
// Word-addressed instruction store mapped at IM_ADDR_BASE. Reads are registered,
// so a request accepted at one clock edge has its response on the next cycle.
// A one-entry response register is held until it is consumed or flushed.
//
// Ports:
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   flush               drop the held response and refuse a request this cycle
//   req_valid/req_ready fetch request handshake
//   req_addr            fetch byte address
//   rsp_valid/rsp_ready response handshake
//   rsp_data            instruction word, bit 0 = MSB (PPC ordering)
//   rsp_fault           {out_of_range, misaligned}
//   ld_en/ld_addr/ld_data  back-door loader write port (word indexed)
module im_fetch_port #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    IM_WIDTH     = 32,
  parameter int                    IM_DEPTH     = 10,
  parameter logic [ADDR_WIDTH-1:0] IM_ADDR_BASE = 'h0000_3000,
  parameter logic [IM_WIDTH-1:0]   FAULT_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [0:IM_WIDTH-1]   rsp_data,
  output logic [1:0]            rsp_fault,
  input  logic                  ld_en,
  input  logic [IM_DEPTH-1:0]   ld_addr,
  input  logic [IM_WIDTH-1:0]   ld_data
);

  typedef enum logic {RSP_EMPTY = 1'b0, RSP_FULL = 1'b1} rsp_state_t;

  rsp_state_t state, state_nxt;

  logic [IM_WIDTH-1:0]   mem [2**IM_DEPTH];
  logic [IM_WIDTH-1:0]   data_q;
  logic [1:0]            fault_q;
  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] off_w;
  logic [IM_DEPTH-1:0]   idx;

  assign rsp_valid = (state == RSP_FULL);

  // Loader writes and reads never share a cycle, so the store needs one port.
  assign req_ready = rst_n && !flush && !ld_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Offset wraps modulo 2**ADDR_WIDTH; addresses below the base are caught by
  // the explicit compare, anything past the top word by the high offset bits.
  assign off          = req_addr - IM_ADDR_BASE;
  assign off_w        = off >> 2;
  assign idx          = off_w[IM_DEPTH-1:0];
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr < IM_ADDR_BASE) || ((off_w >> IM_DEPTH) != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      RSP_EMPTY: if (accept) state_nxt = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !accept) state_nxt = RSP_EMPTY;
      default:   state_nxt = RSP_EMPTY;
    endcase
    if (flush) state_nxt = RSP_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RSP_EMPTY;
    else        state <= state_nxt;
  end

  // Response register only moves on accept, so a held or consumed response
  // keeps its data and fault bits. Faulting fetches never touch the store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      fault_q <= 2'b00;
    end else if (accept) begin
      fault_q <= {out_of_range, misaligned};
      data_q  <= (misaligned || out_of_range) ? FAULT_WORD : mem[idx];
    end
  end

  // Store contents survive reset; a loader write in a reset cycle still lands.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Plain positional assignment: the MSB of the stored word lands on bit 0.
  assign rsp_data  = data_q;
  assign rsp_fault = fault_q;

endmodule

// File: doc/im_fetch_port.md
Name: im_fetch_port

Overview:
- Parametrised, synchronous successor to the combinational instruction memory.
- Word-addressed instruction store with a base-address window and a registered one-cycle read.
- valid/ready request and response handshake; alignment and range fault reporting.
- Back-door loader write port for program preload; flush input for branch redirects.
- Sits between the IF-stage PC logic and the IF/ID pipeline register.

Parameters:
- ADDR_WIDTH, 32, width of fetch byte address.
- IM_WIDTH, 32, instruction word width in bits.
- IM_DEPTH, 10, log2 of word count (store holds 2**IM_DEPTH words).
- IM_ADDR_BASE, 32'h0000_3000, byte address of word 0.
- FAULT_WORD, 32'h0000_0000, value driven on rsp_data for a faulting fetch.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  discard held response; block acceptance this cycle.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  fetch byte address.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  [0:IM_WIDTH-1]  instruction word, PPC bit order (bit 0 = MSB).
- rsp_fault  out  2  bit0 misaligned, bit1 out-of-range.
- ld_en  in  1  loader write strobe.
- ld_addr  in  IM_DEPTH  loader word index.
- ld_data  in  IM_WIDTH  loader write data.

Behaviour:
- Reset (rst_n=0 at posedge): rsp_valid=0, rsp_data=0, rsp_fault=0. Memory contents are not reset. req_ready=0 while rst_n=0.
- req_ready = rst_n && !flush && !ld_en && (!rsp_valid || rsp_ready). Combinational; does not depend on req_valid.
- Address decode on accept:
  - off = req_addr - IM_ADDR_BASE, computed modulo 2**ADDR_WIDTH.
  - misaligned = req_addr[1:0] != 0.
  - out_of_range = req_addr < IM_ADDR_BASE || off[ADDR_WIDTH-1:IM_DEPTH+2] != 0.
  - Word index = off[IM_DEPTH+1:2].
- Response timing:
  - Latency is exactly 1 cycle. Accept at edge N gives rsp_valid=1 after edge N.
  - Non-faulting fetch: rsp_data = mem[index] as of edge N.
  - Either fault set: rsp_data = FAULT_WORD. Memory is not read, and both fault bits may be 1.
- Hold: while rsp_valid && !rsp_ready, rsp_data and rsp_fault are stable and no new request is accepted.
- Throughput: rsp_ready=1 with a new accept in the same cycle replaces the response back-to-back. This gives one fetch per cycle.
- Consume without new accept: rsp_valid && rsp_ready && !accept gives rsp_valid=0 next cycle. rsp_data and rsp_fault keep their last values.
- flush=1: rsp_valid=0 next cycle; no accept that cycle; rsp_ready is ignored. flush takes precedence over everything except reset.
- Loader:
  - ld_en=1 writes mem[ld_addr] <= ld_data at the edge.
  - req_ready=0 that cycle, so a read and a write never occur in the same cycle.
  - A held response keeps its captured data even if ld_addr overwrites the same word.
- Reset mid-operation: a pending response is dropped. A loader write in the reset cycle is still performed. Memory is untouched otherwise.
- State: RSP_EMPTY / RSP_FULL, held as rsp_valid.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on rsp_ready && accept, or on !rsp_ready.
  - FULL -> EMPTY on rsp_ready && !accept, or on flush.

Test Plan:
- Preload via ld_en mem[0]=32'h3860_0001 and mem[5]=32'h4800_0010. Fetch 0x3000 then 0x3014 with rsp_ready=1 -> rsp_valid on consecutive cycles; data 3860_0001 then 4800_0010; rsp_fault=0.
- Fetch 0x3002 -> rsp_fault=2'b01, rsp_data=FAULT_WORD. Fetch 0x2FFC -> 2'b10. Fetch 0x4002 -> 2'b11 (DEPTH=10, top word 0x3FFC; 0x4000 is out of range).
- Backpressure: hold rsp_ready=0 for 3 cycles after accept of 0x3000 -> req_ready=0 and rsp_data stable at 3860_0001. Raising rsp_ready with req_valid at 0x3014 -> handoff in that cycle; next rsp_data 4800_0010.
- Flush with response held and req_valid=1 -> rsp_valid=0 next cycle, no accept that cycle. Accept occurs the following cycle.
- Loader overwriting mem[0]=0 while the fetch of 0x3000 is held -> held rsp_data stays 3860_0001, req_ready=0 during ld_en. A refetch returns 0.
- Assert rst_n=0 with rsp_valid=1 -> next cycle rsp_valid=0, rsp_data=0, rsp_fault=0. Memory reads back preloaded values after release.
